// File: rtl/multicycle_controller.sv
// multicycle_controller: control unit for a multicycle RV32I subset core.
// A Moore FSM sequences each instruction through the datapath. Combinational
// decoders produce ALUControl and ImmSrc from the instruction fields.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] state_dbg
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    logic [3:0] state, state_nxt;
    logic [1:0] aluop;
    logic       branch, pcupdate;
    logic       adrsrc_s, irwrite_s, memwrite_s, regwrite_s;
    logic [1:0] resultsrc_s, alusrca_s, alusrcb_s;

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    // Next-state selection; unused codes 11-15 fall back to FETCH.
    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:    state_nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = S_EXECUTER;
                    OP_I:         state_nxt = S_EXECUTEI;
                    OP_JAL:       state_nxt = S_JAL;
                    OP_BEQ:       state_nxt = S_BEQ;
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR:   state_nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_nxt = S_MEMWB;
            S_EXECUTER,
            S_EXECUTEI,
            S_JAL:      state_nxt = S_ALUWB;
            default:    state_nxt = S_FETCH;
        endcase
    end

    // Moore outputs per state; anything not named for a state stays 0.
    always_comb begin
        adrsrc_s    = 1'b0;
        irwrite_s   = 1'b0;
        memwrite_s  = 1'b0;
        regwrite_s  = 1'b0;
        resultsrc_s = 2'b00;
        alusrca_s   = 2'b00;
        alusrcb_s   = 2'b00;
        aluop       = 2'b00;
        branch      = 1'b0;
        pcupdate    = 1'b0;
        case (state)
            S_FETCH: begin
                irwrite_s   = 1'b1;
                alusrcb_s   = 2'b10;
                resultsrc_s = 2'b10;
                pcupdate    = 1'b1;
            end
            S_DECODE: begin
                alusrca_s = 2'b01;
                alusrcb_s = 2'b01;
            end
            S_MEMADR: begin
                alusrca_s = 2'b10;
                alusrcb_s = 2'b01;
            end
            S_MEMREAD:  adrsrc_s = 1'b1;
            S_MEMWB: begin
                resultsrc_s = 2'b01;
                regwrite_s  = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc_s   = 1'b1;
                memwrite_s = 1'b1;
            end
            S_EXECUTER: begin
                alusrca_s = 2'b10;
                aluop     = 2'b10;
            end
            S_EXECUTEI: begin
                alusrca_s = 2'b10;
                alusrcb_s = 2'b01;
                aluop     = 2'b10;
            end
            S_ALUWB:    regwrite_s = 1'b1;
            S_BEQ: begin
                alusrca_s = 2'b10;
                aluop     = 2'b01;
                branch    = 1'b1;
            end
            S_JAL: begin
                alusrca_s = 2'b01;
                alusrcb_s = 2'b10;
                pcupdate  = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU decoder; subtract only for R-type with funct7b5 (op[5] separates R from I).
    always_comb begin
        ALUControl = 3'b000;
        case (aluop)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Immediate format select from opcode.
    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Write enables are masked during reset; selects simply follow state.
    assign PCWrite   = ~reset & (pcupdate | (branch & Zero));
    assign IRWrite   = ~reset & irwrite_s;
    assign MemWrite  = ~reset & memwrite_s;
    assign RegWrite  = ~reset & regwrite_s;
    assign AdrSrc    = adrsrc_s;
    assign ResultSrc = resultsrc_s;
    assign ALUSrcA   = alusrca_s;
    assign ALUSrcB   = alusrcb_s;
    assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// through its state sequence and checks outputs against hand-derived values.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
        tick; tick;
        chk("rst_state", state_dbg, 0);
        chk("rst_irwrite", IRWrite, 0);
        chk("rst_pcwrite", PCWrite, 0);
        reset = 1'b0;
        #1;
        chk("fetch_irwrite", IRWrite, 1);
        chk("fetch_pcwrite", PCWrite, 1);
        chk("fetch_resultsrc", ResultSrc, 2'b10);
        chk("fetch_alusrcb", ALUSrcB, 2'b10);

        // R-type add: 0,1,6,8,0
        tick; chk("r_s1", state_dbg, 1); chk("r_dec_regwrite", RegWrite, 0);
        chk("r_dec_alusrca", ALUSrcA, 2'b01);
        tick; chk("r_s6", state_dbg, 6); chk("r_add_alu", ALUControl, 3'b000);
        chk("r_exe_regwrite", RegWrite, 0);
        funct3 = 3'b010; #1; chk("r_slt_alu", ALUControl, 3'b101);
        funct3 = 3'b110; #1; chk("r_or_alu", ALUControl, 3'b011);
        funct3 = 3'b111; #1; chk("r_and_alu", ALUControl, 3'b010);
        funct3 = 3'b000;
        tick; chk("r_s8", state_dbg, 8); chk("r_wb_regwrite", RegWrite, 1);
        chk("r_wb_resultsrc", ResultSrc, 2'b00);
        tick; chk("r_s0", state_dbg, 0); chk("r_fetch_regwrite", RegWrite, 0);

        // lw: 0,1,2,3,4
        op = 7'b0000011;
        tick; chk("lw_s1", state_dbg, 1); chk("lw_immsrc", ImmSrc, 2'b00);
        tick; chk("lw_s2", state_dbg, 2); chk("lw_alusrca", ALUSrcA, 2'b10);
        chk("lw_alusrcb", ALUSrcB, 2'b01);
        tick; chk("lw_s3", state_dbg, 3); chk("lw_adrsrc", AdrSrc, 1);
        tick; chk("lw_s4", state_dbg, 4); chk("lw_resultsrc", ResultSrc, 2'b01);
        chk("lw_regwrite", RegWrite, 1);
        tick; chk("lw_s0", state_dbg, 0);

        // beq taken then not taken
        op = 7'b1100011; Zero = 1'b1;
        tick; chk("beq1_s1", state_dbg, 1); chk("beq_immsrc", ImmSrc, 2'b10);
        tick; chk("beq1_s9", state_dbg, 9); chk("beq1_pcwrite", PCWrite, 1);
        chk("beq1_alu", ALUControl, 3'b001);
        tick; chk("beq1_s0", state_dbg, 0);
        Zero = 1'b0;
        tick; chk("beq0_s1", state_dbg, 1);
        tick; chk("beq0_s9", state_dbg, 9); chk("beq0_pcwrite", PCWrite, 0);
        tick; chk("beq0_s0", state_dbg, 0);

        // R-type sub, then I-type with identical fields stays add
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        tick; tick; chk("sub_s6", state_dbg, 6); chk("sub_alu", ALUControl, 3'b001);
        tick; tick; chk("sub_s0", state_dbg, 0);
        op = 7'b0010011;
        tick; tick; chk("addi_s7", state_dbg, 7); chk("addi_alu", ALUControl, 3'b000);
        chk("addi_alusrcb", ALUSrcB, 2'b01);
        tick; chk("addi_s8", state_dbg, 8);
        tick; chk("addi_s0", state_dbg, 0);
        funct7b5 = 1'b0;

        // jal: 0,1,10,8,0
        op = 7'b1101111;
        tick; chk("jal_s1", state_dbg, 1); chk("jal_immsrc", ImmSrc, 2'b11);
        tick; chk("jal_s10", state_dbg, 10); chk("jal_pcwrite", PCWrite, 1);
        chk("jal_alusrcb", ALUSrcB, 2'b10);
        tick; chk("jal_s8", state_dbg, 8);
        tick; chk("jal_s0", state_dbg, 0);

        // unsupported opcode: 0,1,0 with no enables in DECODE
        op = 7'b0000000;
        tick; chk("bad_s1", state_dbg, 1); chk("bad_regwrite", RegWrite, 0);
        chk("bad_memwrite", MemWrite, 0); chk("bad_pcwrite", PCWrite, 0);
        tick; chk("bad_s0", state_dbg, 0);

        // sw aborted by reset in MEMWRITE
        op = 7'b0100011;
        tick; chk("sw_s1", state_dbg, 1); chk("sw_immsrc", ImmSrc, 2'b01);
        tick; chk("sw_s2", state_dbg, 2);
        tick; chk("sw_s5", state_dbg, 5); chk("sw_memwrite", MemWrite, 1);
        reset = 1'b1; #1;
        chk("sw_rst_memwrite", MemWrite, 0);
        chk("sw_rst_adrsrc", AdrSrc, 1);
        tick; chk("sw_rst_s0", state_dbg, 0); chk("sw_rst_irwrite", IRWrite, 0);
        reset = 1'b0;
        tick; chk("post_rst_s1", state_dbg, 1); chk("post_rst_memwrite", MemWrite, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have no parameters.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op  in  7  instruction opcode field.
REQ-005 funct3  in  3  instruction funct3 field.
REQ-006 funct7b5  in  1  instruction bit 30.
REQ-007 Zero  in  1  ALU zero flag.
REQ-008 PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite  out  1 each  datapath enables and selects.
REQ-009 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  out  2 each  datapath mux selects.
REQ-010 ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-011 state_dbg  out  4  current state encoding, per REQ-014.

Function
REQ-012 SHALL be a Moore FSM plus combinational ALU decoder; only PCWrite (Zero) and ALUControl/ImmSrc (fields) depend on inputs within a cycle.
REQ-013 SHALL sample op/funct3/funct7b5 combinationally; the datapath holds them stable from DECODE through instruction end.
REQ-014 States/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10; codes 11-15 SHALL transition to FETCH.
REQ-015 Transitions: FETCH->DECODE; DECODE: op 0000011/0100011->MEMADR, 0110011->EXECUTER, 0010011->EXECUTEI, 1101111->JAL, 1100011->BEQ, other->FETCH.
REQ-016 MEMADR: op 0000011->MEMREAD, else->MEMWRITE; MEMREAD->MEMWB; EXECUTER, EXECUTEI, JAL->ALUWB; MEMWB, MEMWRITE, ALUWB, BEQ->FETCH.
REQ-017 Any output not listed for a state SHALL be 0; ALUOp is internal (2 bits).
REQ-018 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
REQ-019 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.  MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
REQ-020 MEMREAD: AdrSrc=1, ResultSrc=00.  MEMWB: ResultSrc=01, RegWrite=1.  MEMWRITE: AdrSrc=1, MemWrite=1.
REQ-021 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.  EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.  ALUWB: ResultSrc=00, RegWrite=1.
REQ-022 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, Branch=1.  JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, PCUpdate=1.
REQ-023 PCWrite SHALL equal PCUpdate OR (Branch AND Zero).
REQ-024 ALUControl: ALUOp 00->000; 01->001; 10 by funct3: 000->001 if (op[5] AND funct7b5) else 000; 010->101; 110->011; 111->010; other funct3->000; ALUOp 11->000.
REQ-025 ImmSrc: op 0000011/0010011->00; 0100011->01; 1100011->10; 1101111->11; other->00.
REQ-026 Latency: lw 5 cycles, sw/R/I/jal 4, beq 3, unsupported op 2 (FETCH, DECODE) with no write enable asserted in DECODE.

Reset
REQ-027 reset high at a rising edge SHALL load FETCH regardless of current state.
REQ-028 While reset is high, PCWrite, IRWrite, MemWrite, RegWrite SHALL be forced 0; other outputs follow state.
REQ-029 Reset asserted mid-instruction SHALL abort it; no further enable pulses of that instruction.

Verification
REQ-030 reset 2 cycles, release, op=0110011 funct3=000 funct7b5=0 -> state_dbg 0,1,6,8,0; RegWrite=1 only in state 8; ALUControl=000 in state 6.
REQ-031 op=0000011 -> state_dbg 0,1,2,3,4; AdrSrc=1 in 3; ResultSrc=01 and RegWrite=1 in 4; ImmSrc=00.
REQ-032 op=1100011, Zero=1 in BEQ -> PCWrite=1, ALUControl=001; repeat with Zero=0 -> PCWrite=0; next state 0 both cases.
REQ-033 op=0110011 funct3=000 funct7b5=1 -> ALUControl=001 in state 6; op=0010011 same fields -> ALUControl=000 in state 7.
REQ-034 op=0000000 -> state_dbg 0,1,0; RegWrite, MemWrite, PCWrite all 0 in DECODE.
REQ-035 op=0100011, reset high while in MEMWRITE -> MemWrite=0 that cycle; state_dbg=0 next cycle.
